// File: rtl/map_switch_ctl_pkg.sv
// Shared types for the mapper-switch sequencer: FSM state encoding and a
// small helper used to classify the states in which requests are refused.
package map_switch_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_QUIET = 2'd1,
        ST_HOLD_RST   = 2'd2,
        ST_RELEASE    = 2'd3
    } state_e;

    // True while the hub is held on nominal output and the new index is settling.
    function automatic logic in_swap_window(input state_e st);
        logic res;
        case (st)
            ST_HOLD_RST: res = 1'b1;
            ST_RELEASE:  res = 1'b1;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/map_switch_ctl.sv
// Mapper-switch sequencer: waits for a quiet console bus (or a timeout), then
// holds the hub on nominal output with the mapper in reset while the index changes.
module map_switch_ctl
    import map_switch_ctl_pkg::*;
#(
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned RST_IDX  = 0,
    parameter int unsigned IDLE_CYC = 16,
    parameter int unsigned RST_CYC  = 8,
    parameter int unsigned TMO_CYC  = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_stb,
    input  logic [IDX_W-1:0] req_idx,
    input  logic             bus_act,
    output logic [IDX_W-1:0] cur_idx,
    output logic             map_rst,
    output logic             bus_hold,
    output logic             busy,
    output logic             ack,
    output logic             req_rej,
    output logic             forced
);

    localparam int unsigned CNT_W  = $clog2(TMO_CYC + 1);
    localparam int unsigned RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [CNT_W-1:0]  IDLE_LIM = CNT_W'(IDLE_CYC);
    localparam logic [CNT_W-1:0]  TMO_LIM  = CNT_W'(TMO_CYC);
    localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_RST  = IDX_W'(RST_IDX);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RCNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic               map_rst_q, map_rst_d;
    logic               bus_hold_q, bus_hold_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               req_rej_q, req_rej_d;
    logic               forced_q, forced_d;

    logic               accept_s;
    logic               same_s;
    logic               tmo_exit_s;
    logic               swap_s;

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idle_cnt_q <= {CNT_W{1'b0}};
            tmo_cnt_q  <= {CNT_W{1'b0}};
            rst_cnt_q  <= {RCNT_W{1'b0}};
            pend_idx_q <= IDX_RST;
            cur_idx_q  <= IDX_RST;
            map_rst_q  <= 1'b0;
            bus_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            req_rej_q  <= 1'b0;
            forced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            pend_idx_q <= pend_idx_d;
            cur_idx_q  <= cur_idx_d;
            map_rst_q  <= map_rst_d;
            bus_hold_q <= bus_hold_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            req_rej_q  <= req_rej_d;
            forced_q   <= forced_d;
        end
    end

    // Next-state and counter logic; the idle exit is tested first so it wins a tie.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        pend_idx_d = pend_idx_q;
        accept_s   = 1'b0;
        same_s     = 1'b0;
        tmo_exit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_stb) begin
                    if (req_idx != cur_idx_q) begin
                        accept_s   = 1'b1;
                        pend_idx_d = req_idx;
                        idle_cnt_d = {CNT_W{1'b0}};
                        tmo_cnt_d  = {CNT_W{1'b0}};
                        state_d    = ST_WAIT_QUIET;
                    end else begin
                        same_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_QUIET: begin
                if (bus_act) begin
                    idle_cnt_d = {CNT_W{1'b0}};
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                if (req_stb) begin
                    pend_idx_d = req_idx;
                end else begin
                    pend_idx_d = pend_idx_q;
                end
                if (idle_cnt_d == IDLE_LIM) begin
                    state_d   = ST_HOLD_RST;
                    rst_cnt_d = {RCNT_W{1'b0}};
                end else if (tmo_cnt_d == TMO_LIM) begin
                    state_d    = ST_HOLD_RST;
                    rst_cnt_d  = {RCNT_W{1'b0}};
                    tmo_exit_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_QUIET;
                end
            end
            ST_HOLD_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_RELEASE;
                    rst_cnt_d = {RCNT_W{1'b0}};
                end else begin
                    rst_cnt_d = rst_cnt_q + RCNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the state being entered.
    always_comb begin
        swap_s     = (state_q == ST_WAIT_QUIET) && (state_d == ST_HOLD_RST);
        cur_idx_d  = swap_s ? pend_idx_d : cur_idx_q;
        map_rst_d  = (state_d == ST_HOLD_RST);
        bus_hold_d = in_swap_window(state_d);
        busy_d     = (state_d != ST_IDLE);
        ack_d      = (state_d == ST_RELEASE) || same_s;
        req_rej_d  = req_stb && in_swap_window(state_q);
        if (accept_s) begin
            forced_d = 1'b0;
        end else if (tmo_exit_s) begin
            forced_d = 1'b1;
        end else begin
            forced_d = forced_q;
        end
    end

    assign cur_idx  = cur_idx_q;
    assign map_rst  = map_rst_q;
    assign bus_hold = bus_hold_q;
    assign busy     = busy_q;
    assign ack      = ack_q;
    assign req_rej  = req_rej_q;
    assign forced   = forced_q;

endmodule
